seg_display_sampler: RTL and testbench



---
 rtl/seg_pkg.sv | 52 +++++
 rtl/seg_display_sampler_if.sv | 27 ++
 rtl/seg7_decode.sv | 23 ++
 rtl/seg_display_sampler.sv | 87 ++++++++
 tb/tb_seg_display_sampler.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared widths, active-low segment constants and the 0-F segment decode table
// used by the display sampler.
package seg_pkg;

  localparam int unsigned SEG_W = 7;
  localparam int unsigned NIB_W = 4;

  localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
  localparam logic [SEG_W-1:0] SEG_A     = 7'h08;
  localparam logic [SEG_W-1:0] SEG_B     = 7'h03;
  localparam logic [SEG_W-1:0] SEG_C     = 7'h46;
  localparam logic [SEG_W-1:0] SEG_D     = 7'h21;
  localparam logic [SEG_W-1:0] SEG_E     = 7'h06;
  localparam logic [SEG_W-1:0] SEG_F     = 7'h0E;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  // Returns {invalid, nibble}; unknown patterns decode to nibble 0 with invalid set.
  function automatic logic [NIB_W:0] seg_decode(input logic [SEG_W-1:0] seg);
    logic [NIB_W:0] r;
    r = {1'b1, 4'h0};
    case (seg)
      SEG_0: r = {1'b0, 4'h0};
      SEG_1: r = {1'b0, 4'h1};
      SEG_2: r = {1'b0, 4'h2};
      SEG_3: r = {1'b0, 4'h3};
      SEG_4: r = {1'b0, 4'h4};
      SEG_5: r = {1'b0, 4'h5};
      SEG_6: r = {1'b0, 4'h6};
      SEG_7: r = {1'b0, 4'h7};
      SEG_8: r = {1'b0, 4'h8};
      SEG_9: r = {1'b0, 4'h9};
      SEG_A: r = {1'b0, 4'hA};
      SEG_B: r = {1'b0, 4'hB};
      SEG_C: r = {1'b0, 4'hC};
      SEG_D: r = {1'b0, 4'hD};
      SEG_E: r = {1'b0, 4'hE};
      SEG_F: r = {1'b0, 4'hF};
      default: r = {1'b1, 4'h0};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg_display_sampler_if.sv
// Snapshot output channel of the display sampler: decoded digits, invalid mask,
// and valid/ready handshake.
interface seg_display_sampler_if #(
  parameter int unsigned N_DIGITS = 6
);
  import seg_pkg::*;

  logic [NIB_W*N_DIGITS-1:0] out_value;
  logic [N_DIGITS-1:0]       out_invalid_mask;
  logic                      out_valid;
  logic                      out_ready;

  modport master (
    output out_value,
    output out_invalid_mask,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_value,
    input  out_invalid_mask,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/seg7_decode.sv
// Combinational single-digit decoder: normalises polarity to active-low, then
// looks the pattern up in the 0-F table.
module seg7_decode
  import seg_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [SEG_W-1:0] seg,
  output logic [NIB_W-1:0] nibble_c,
  output logic             invalid_c
);

  logic [SEG_W-1:0] seg_al;
  logic [NIB_W:0]   dec;

  always_comb begin
    seg_al    = ACTIVE_LOW ? seg : ~seg;
    dec       = seg_decode(seg_al);
    nibble_c  = dec[NIB_W-1:0];
    invalid_c = dec[NIB_W];
  end

endmodule

// File: rtl/seg_display_sampler.sv
// Debounces N_DIGITS seven-segment buses and emits each new stable snapshot,
// decoded to hex, on a valid/ready channel with saturating drop accounting.
module seg_display_sampler
  import seg_pkg::*;
#(
  parameter int unsigned N_DIGITS      = 6,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter bit          ACTIVE_LOW    = 1'b1,
  parameter int unsigned OVF_W         = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [SEG_W*N_DIGITS-1:0] segs_in,
  seg_display_sampler_if.master     snap,
  output logic [OVF_W-1:0]          overflow_count
);

  localparam int unsigned BUS_W = SEG_W * N_DIGITS;
  localparam int unsigned VAL_W = NIB_W * N_DIGITS;
  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  // Raw-bus image of every segment dark, in the input polarity.
  localparam logic [BUS_W-1:0] BLANK_BUS =
    ACTIVE_LOW ? {N_DIGITS{SEG_BLANK}} : BUS_W'(0);

  logic [BUS_W-1:0]    seg_q;
  logic [BUS_W-1:0]    last_rep;
  logic [CNT_W-1:0]    stab_cnt;
  logic [VAL_W-1:0]    dec_value_c;
  logic [N_DIGITS-1:0] dec_invalid_c;
  logic                event_c;
  logic                xfer_c;

  for (genvar i = 0; i < N_DIGITS; i++) begin : g_dec
    seg7_decode #(.ACTIVE_LOW(ACTIVE_LOW)) u_dec (
      .seg       (seg_q[SEG_W*i +: SEG_W]),
      .nibble_c  (dec_value_c[NIB_W*i +: NIB_W]),
      .invalid_c (dec_invalid_c[i])
    );
  end

  always_comb begin
    event_c = enable && (stab_cnt == CNT_MAX) && (seg_q != last_rep);
    xfer_c  = snap.out_valid && snap.out_ready;
  end

  // Sampling and stability tracking.
  always_ff @(posedge clock) begin
    if (reset) begin
      seg_q    <= BLANK_BUS;
      last_rep <= BLANK_BUS;
      stab_cnt <= '0;
    end else begin
      seg_q <= segs_in;
      if (!enable)
        stab_cnt <= '0;
      else if (segs_in != seg_q)
        stab_cnt <= CNT_W'(1);
      else if (stab_cnt != CNT_MAX)
        stab_cnt <= stab_cnt + CNT_W'(1);
      if (event_c)
        last_rep <= seg_q;
    end
  end

  // Output register; a blocked event is dropped but still marks last_rep.
  always_ff @(posedge clock) begin
    if (reset) begin
      snap.out_valid        <= 1'b0;
      snap.out_value        <= '0;
      snap.out_invalid_mask <= '0;
      overflow_count        <= '0;
    end else if (event_c) begin
      if (!snap.out_valid || snap.out_ready) begin
        snap.out_valid        <= 1'b1;
        snap.out_value        <= dec_value_c;
        snap.out_invalid_mask <= dec_invalid_c;
      end else if (overflow_count != {OVF_W{1'b1}}) begin
        overflow_count <= overflow_count + OVF_W'(1);
      end
    end else if (xfer_c) begin
      snap.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg_display_sampler.sv
// Directed bench for seg_display_sampler: reset, latency, debounce, backpressure
// drops, invalid patterns, same-edge transfer and mid-report reset.
module tb_seg_display_sampler;

  localparam int unsigned ND = 6;

  localparam logic [6:0] C0 = 7'h40;
  localparam logic [6:0] C1 = 7'h79;
  localparam logic [6:0] C2 = 7'h24;
  localparam logic [6:0] C3 = 7'h30;
  localparam logic [6:0] C4 = 7'h19;
  localparam logic [6:0] C5 = 7'h12;
  localparam logic [6:0] C6 = 7'h02;
  localparam logic [6:0] C7 = 7'h78;
  localparam logic [6:0] CB = 7'h7F;
  localparam logic [6:0] CX = 7'h7E;

  logic          clock;
  logic          reset;
  logic          enable;
  logic [41:0]   segs_in;
  logic [15:0]   overflow_count;

  int checks = 0;
  int errors = 0;

  seg_display_sampler_if #(.N_DIGITS(ND)) snap ();

  seg_display_sampler #(
    .N_DIGITS(ND), .STABLE_CYCLES(4), .ACTIVE_LOW(1'b1), .OVF_W(16)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .segs_in        (segs_in),
    .snap           (snap),
    .overflow_count (overflow_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [41:0] mk(input logic [6:0] d5, d4, d3, d2, d1, d0);
    return {d5, d4, d3, d2, d1, d0};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset             = 1'b1;
    enable            = 1'b1;
    snap.out_ready    = 1'b1;
    segs_in           = mk(CB, CB, CB, CB, CB, CB);

    // 1: reset and idle blank bus
    tick(); tick();
    chk("rst_valid", 32'(snap.out_valid), 32'd0);
    chk("rst_value", 32'(snap.out_value), 32'h0);
    chk("rst_mask",  32'(snap.out_invalid_mask), 32'h0);
    chk("rst_ovf",   32'(overflow_count), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("blank_no_report", 32'(snap.out_valid), 32'd0);
    end
    chk("blank_ovf", 32'(overflow_count), 32'd0);

    // 2: latency of a held pattern
    segs_in = mk(C6, C5, C4, C3, C2, C1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("lat_wait", 32'(snap.out_valid), 32'd0);
    end
    tick();
    chk("lat_valid", 32'(snap.out_valid), 32'd1);
    chk("lat_value", 32'(snap.out_value), 32'h654321);
    chk("lat_mask",  32'(snap.out_invalid_mask), 32'h0);
    tick();
    chk("lat_one_cycle", 32'(snap.out_valid), 32'd0);

    // 3: short-lived "1" is debounced away, "7" reported once
    segs_in = mk(C0, C0, C0, C0, C0, C1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("deb_short", 32'(snap.out_valid), 32'd0);
    end
    segs_in = mk(C0, C0, C0, C0, C0, C7);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("deb_wait", 32'(snap.out_valid), 32'd0);
    end
    tick();
    chk("deb_valid", 32'(snap.out_valid), 32'd1);
    chk("deb_value", 32'(snap.out_value), 32'h000007);
    tick();
    chk("deb_once", 32'(snap.out_valid), 32'd0);

    // 4: backpressure drops B while A is held
    snap.out_ready = 1'b0;
    segs_in = mk(C1, C1, C1, C1, C1, C1);
    for (int i = 0; i < 5; i++) tick();
    chk("bp_a_valid", 32'(snap.out_valid), 32'd1);
    chk("bp_a_value", 32'(snap.out_value), 32'h111111);
    segs_in = mk(C2, C2, C2, C2, C2, C2);
    for (int i = 0; i < 5; i++) tick();
    chk("bp_hold_value", 32'(snap.out_value), 32'h111111);
    chk("bp_hold_valid", 32'(snap.out_valid), 32'd1);
    chk("bp_ovf", 32'(overflow_count), 32'd1);
    tick(); tick();
    chk("bp_ovf_once", 32'(overflow_count), 32'd1);
    snap.out_ready = 1'b1;
    tick();
    chk("bp_accept", 32'(snap.out_valid), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("bp_b_dropped", 32'(snap.out_valid), 32'd0);
    end

    // 5: undecodable digit 2
    segs_in = mk(C0, C0, C0, CX, C0, C0);
    for (int i = 0; i < 5; i++) tick();
    chk("inv_valid", 32'(snap.out_valid), 32'd1);
    chk("inv_value", 32'(snap.out_value), 32'h000000);
    chk("inv_mask",  32'(snap.out_invalid_mask), 32'h04);
    tick();
    chk("inv_clear", 32'(snap.out_valid), 32'd0);

    // 6: same-edge transfer + event, then reset mid-report
    snap.out_ready = 1'b0;
    segs_in = mk(C3, C3, C3, C3, C3, C3);
    for (int i = 0; i < 5; i++) tick();
    chk("se_c_value", 32'(snap.out_value), 32'h333333);
    segs_in = mk(C4, C4, C4, C4, C4, C4);
    for (int i = 0; i < 4; i++) tick();
    chk("se_c_held", 32'(snap.out_value), 32'h333333);
    snap.out_ready = 1'b1;
    tick();
    chk("se_valid", 32'(snap.out_valid), 32'd1);
    chk("se_value", 32'(snap.out_value), 32'h444444);
    chk("se_ovf",   32'(overflow_count), 32'd1);
    snap.out_ready = 1'b0;
    reset = 1'b1;
    tick();
    chk("mrst_valid", 32'(snap.out_valid), 32'd0);
    chk("mrst_value", 32'(snap.out_value), 32'h0);
    chk("mrst_ovf",   32'(overflow_count), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mrst_wait", 32'(snap.out_valid), 32'd0);
    end
    tick();
    chk("mrst_rereport", 32'(snap.out_valid), 32'd1);
    chk("mrst_rereport_value", 32'(snap.out_value), 32'h444444);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
